// File: rtl/oam_dma_ctrl.sv
// Sprite OAM access controller: CPU-driven OAMADDR/OAMDATA writes plus the
// 256-byte page DMA that halts the CPU and copies a memory page into OAM.
module oam_dma_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_halt,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_dma
);

  localparam logic [15:0] ADDR_OAMADDR = 16'h2003;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;
  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_oam_ptr;
  logic [7:0]  r_page;
  logic [7:0]  r_cnt;
  logic        r_cyc_odd;
  logic        r_cpu_halt;
  logic        r_dma_rd;
  logic        r_oam_dma;
  logic [15:0] r_dma_addr;
  logic [7:0]  r_oam_addr;
  logic [7:0]  r_oam_data;

  logic [7:0]  w_cnt_inc;
  logic        w_in_write;

  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_in_write = (r_state == S_WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_oam_ptr  <= 8'h00;
      r_page     <= 8'h00;
      r_cnt      <= 8'h00;
      r_cyc_odd  <= 1'b0;
      r_cpu_halt <= 1'b0;
      r_dma_rd   <= 1'b0;
      r_oam_dma  <= 1'b0;
      r_dma_addr <= 16'h0000;
      r_oam_addr <= 8'h00;
      r_oam_data <= 8'h00;
    end else begin
      r_cyc_odd <= ~r_cyc_odd;
      unique case (r_state)
        S_IDLE: begin
          r_dma_rd  <= 1'b0;
          r_oam_dma <= 1'b0;
          if (cpu_we) begin
            // The pointer moves on the same edge so back-to-back data writes land in consecutive slots
            if (cpu_addr == ADDR_OAMADDR) begin
              r_oam_ptr <= cpu_wdata;
            end else if (cpu_addr == ADDR_OAMDATA) begin
              r_oam_dma  <= 1'b1;
              r_oam_addr <= r_oam_ptr;
              r_oam_data <= cpu_wdata;
              r_oam_ptr  <= r_oam_ptr + 8'd1;
            end else if (cpu_addr == ADDR_OAMDMA) begin
              r_page     <= cpu_wdata;
              r_cnt      <= 8'h00;
              r_cpu_halt <= 1'b1;
              r_state    <= S_HALT;
            end
          end
        end
        S_HALT: begin
          if (r_cyc_odd) begin
            r_state <= S_ALIGN;
          end else begin
            r_state    <= S_READ;
            r_dma_rd   <= 1'b1;
            r_dma_addr <= {r_page, r_cnt};
          end
        end
        S_ALIGN: begin
          r_state    <= S_READ;
          r_dma_rd   <= 1'b1;
          r_dma_addr <= {r_page, r_cnt};
        end
        S_READ: begin
          r_state    <= S_WRITE;
          r_dma_rd   <= 1'b0;
          r_oam_dma  <= 1'b1;
          r_oam_addr <= r_oam_ptr + r_cnt;
        end
        S_WRITE: begin
          // Latch the byte just written so oam_data stays stable after the pass-through ends
          r_oam_dma  <= 1'b0;
          r_oam_data <= mem_rdata;
          r_cnt      <= w_cnt_inc;
          if (r_cnt == 8'hFF) begin
            r_state    <= S_IDLE;
            r_cpu_halt <= 1'b0;
          end else begin
            r_state    <= S_READ;
            r_dma_rd   <= 1'b1;
            r_dma_addr <= {r_page, w_cnt_inc};
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cpu_halt <= 1'b0;
          r_dma_rd   <= 1'b0;
          r_oam_dma  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_halt = r_cpu_halt;
  assign dma_rd   = r_dma_rd;
  assign dma_addr = r_dma_addr;
  assign oam_addr = r_oam_addr;
  assign oam_dma  = r_oam_dma;
  assign oam_data = w_in_write ? mem_rdata : r_oam_data;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: expected OAM writes are queued when the
// CPU or DMA stimulus is issued and popped as oam_dma pulses appear.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  mem_rdata;
  logic        cpu_halt;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_dma;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [15:0] expQ[$];
  logic [7:0]  oamShadow [256];
  logic [7:0]  ptrModel;
  logic        tbOdd;
  int          writesSeen;
  int          readsSeen;
  logic [15:0] expDmaAddr;

  oam_dma_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .mem_rdata (mem_rdata),
    .cpu_halt  (cpu_halt),
    .dma_rd    (dma_rd),
    .dma_addr  (dma_addr),
    .oam_addr  (oam_addr),
    .oam_data  (oam_data),
    .oam_dma   (oam_dma)
  );

  always #5 clk = ~clk;

  // Memory answers one clock after a read request; a filler value otherwise exposes mistimed sampling
  always @(posedge clk) begin
    if (dma_rd) mem_rdata <= dma_addr[7:0] ^ 8'h5A;
    else        mem_rdata <= 8'hC3;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    logic [15:0] e;
    @(posedge clk);
    tbOdd = reset ? 1'b0 : ~tbOdd;
    #1;
    if (oam_dma) begin
      writesSeen++;
      if (expQ.size() == 0) begin
        checkOutput("spuriousOamWrite", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("oamAddr", {24'd0, oam_addr}, {24'd0, e[15:8]});
        checkOutput("oamData", {24'd0, oam_data}, {24'd0, e[7:0]});
      end
      oamShadow[oam_addr] = oam_data;
    end
    if (dma_rd) begin
      readsSeen++;
      checkOutput("dmaAddr", {16'd0, dma_addr}, {16'd0, expDmaAddr});
      expDmaAddr = expDmaAddr + 16'd1;
    end
  endtask

  // Single CPU write while the controller is idle, with the expected OAM effect modelled
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data);
    cpu_we    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    if (addr == 16'h2003) begin
      ptrModel = data;
    end else if (addr == 16'h2004) begin
      expQ.push_back({ptrModel, data});
      ptrModel = ptrModel + 8'd1;
    end
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic applyDma(input logic [7:0] page, input logic wantOdd, input int abortAt, input logic inject);
    int haltLen;
    int idx;
    int firstRd;
    logic [7:0] a;
    logic [7:0] d;
    if ((~tbOdd) != wantOdd) tick();
    for (int i = 0; i < 256; i++) begin
      a = ptrModel + 8'(i);
      d = 8'(i) ^ 8'h5A;
      expQ.push_back({a, d});
    end
    expDmaAddr = {page, 8'h00};
    writesSeen = 0;
    readsSeen  = 0;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h4014;
    cpu_wdata = page;
    tick();
    cpu_we = 1'b0;
    checkOutput("haltStart", {31'd0, cpu_halt}, 32'd1);
    checkOutput("haltCycleNoRead", {31'd0, dma_rd}, 32'd0);
    haltLen = 1;
    idx     = 0;
    firstRd = -1;
    while (1) begin
      if (idx >= 2000) begin
        checkOutput("dmaTimeout", 32'd1, 32'd0);
        break;
      end
      cpu_we = 1'b0;
      if (inject && idx == 50) begin
        cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = page + 8'd1;
      end else if (inject && idx == 51) begin
        cpu_we = 1'b1; cpu_addr = 16'h2004; cpu_wdata = 8'hEE;
      end else if (inject && idx == 52) begin
        cpu_we = 1'b1; cpu_addr = 16'h2003; cpu_wdata = 8'h33;
      end
      tick();
      idx++;
      if (dma_rd && firstRd < 0) firstRd = idx;
      if (abortAt < 256 && writesSeen == abortAt) break;
      if (cpu_halt) haltLen++;
      else break;
    end
    cpu_we = 1'b0;
    if (abortAt >= 256) begin
      checkOutput("haltLength", 32'(haltLen), wantOdd ? 32'd514 : 32'd513);
      checkOutput("firstReadCycle", 32'(firstRd), wantOdd ? 32'd2 : 32'd1);
      checkOutput("dmaWriteCount", 32'(writesSeen), 32'd256);
      checkOutput("dmaReadCount", 32'(readsSeen), 32'd256);
      checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
      checkOutput("dmaAddrHeld", {16'd0, dma_addr}, {16'd0, page, 8'hFF});
    end
  endtask

  initial begin
    reset     = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    tbOdd     = 1'b0;
    ptrModel  = 8'h00;
    expDmaAddr = 16'h0000;
    writesSeen = 0;
    readsSeen  = 0;
    repeat (2) tick();
    checkOutput("rstHalt", {31'd0, cpu_halt}, 32'd0);
    checkOutput("rstDmaRd", {31'd0, dma_rd}, 32'd0);
    checkOutput("rstOamDma", {31'd0, oam_dma}, 32'd0);
    checkOutput("rstDmaAddr", {16'd0, dma_addr}, 32'd0);
    checkOutput("rstOamAddr", {24'd0, oam_addr}, 32'd0);
    reset = 1'b0;
    tick();

    applyStimulus(16'h2003, 8'h10);
    applyStimulus(16'h2004, 8'hAB);
    applyStimulus(16'h2004, 8'hCD);
    tick();
    applyStimulus(16'h2005, 8'h99);
    applyStimulus(16'h2004, 8'h3C);
    tick();
    checkOutput("oamAddrHeld", {24'd0, oam_addr}, 32'h12);
    checkOutput("oamDataHeld", {24'd0, oam_data}, 32'h3C);

    applyStimulus(16'h2003, 8'h00);
    applyDma(8'h02, 1'b0, 256, 1'b0);
    checkOutput("oam00", {24'd0, oamShadow[8'h00]}, 32'h5A);
    checkOutput("oam80", {24'd0, oamShadow[8'h80]}, 32'hDA);
    checkOutput("oamFF", {24'd0, oamShadow[8'hFF]}, 32'hA5);
    applyStimulus(16'h2004, 8'h44);

    applyStimulus(16'h2003, 8'h00);
    applyDma(8'h02, 1'b1, 256, 1'b0);

    applyStimulus(16'h2003, 8'hF0);
    applyDma(8'h03, 1'b0, 256, 1'b0);
    checkOutput("wrapByte0", {24'd0, oamShadow[8'hF0]}, 32'h5A);
    checkOutput("wrapByte16", {24'd0, oamShadow[8'h00]}, 32'h4A);
    checkOutput("wrapByte255", {24'd0, oamShadow[8'hEF]}, 32'hA5);
    applyStimulus(16'h2004, 8'h55);

    applyDma(8'h04, 1'b1, 256, 1'b1);
    applyStimulus(16'h2004, 8'h66);

    applyStimulus(16'h2003, 8'h00);
    applyDma(8'h05, 1'b0, 100, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abortHalt", {31'd0, cpu_halt}, 32'd0);
    checkOutput("abortOamDma", {31'd0, oam_dma}, 32'd0);
    checkOutput("abortDmaRd", {31'd0, dma_rd}, 32'd0);
    expQ.delete();
    ptrModel = 8'h00;
    applyStimulus(16'h2004, 8'h77);
    applyStimulus(16'h2003, 8'h00);
    applyDma(8'h02, 1'b1, 256, 1'b0);

    repeat (4) tick();
    checkOutput("finalQueueEmpty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
